// File: rtl/event_trace_player.sv
// event_trace_player: programmable timed-event table that replays per-channel
// value/new-flag pairs into a monitor, with loop mode, stop and fire counting.
module event_trace_player #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 16,
  parameter int DELAY_W = 32,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DELAY_W-1:0]       wr_delay,
  input  logic [NUM_CH-1:0]        wr_mask,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic [AW:0]              num_entries,
  input  logic                     start,
  input  logic                     loop_mode,
  input  logic                     stop,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        new_out,
  output logic                     busy,
  output logic                     done,
  output logic [AW-1:0]            entry_idx,
  output logic [15:0]              fire_count
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_N   = (AW+1)'(1);

  logic [DELAY_W-1:0]       delay_mem [DEPTH];
  logic [NUM_CH-1:0]        mask_mem  [DEPTH];
  logic [NUM_CH*DATA_W-1:0] data_mem  [DEPTH];

  state_t                   state, state_nx;
  logic [AW-1:0]            idx, idx_nx, idx_inc;
  logic [DELAY_W-1:0]       cnt, cnt_nx;
  logic [AW:0]              n_lat, n_nx, n_clip;
  logic                     loop_lat, loop_nx;
  logic [NUM_CH*DATA_W-1:0] data_nx, fire_data;
  logic [NUM_CH-1:0]        new_nx, fire_mask;
  logic [15:0]              fc_nx;
  logic                     start_ok, last_entry;

  assign busy      = (state == WAIT);
  assign done      = (state == DONE);
  assign entry_idx = idx;

  // Table write port; writes are dropped while playback is waiting.
  always_ff @(posedge clk) begin
    if (wr_en && state != WAIT) begin
      delay_mem[wr_addr] <= wr_delay;
      mask_mem[wr_addr]  <= wr_mask;
      data_mem[wr_addr]  <= wr_data;
    end
  end

  // Current entry's payload with unmasked lanes zeroed.
  always_comb begin
    fire_mask = mask_mem[idx];
    fire_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (fire_mask[k])
        fire_data[k*DATA_W +: DATA_W] = data_mem[idx][k*DATA_W +: DATA_W];
    end
  end

  // Next-state, counter, table index and registered output values.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    n_nx     = n_lat;
    loop_nx  = loop_lat;
    data_nx  = data_out;
    new_nx   = '0;
    fc_nx    = fire_count;

    start_ok   = (state == IDLE || state == DONE) && en && start &&
                 (num_entries != '0);
    n_clip     = (num_entries > DEPTH_N) ? DEPTH_N : num_entries;
    idx_inc    = idx + 1'b1;
    last_entry = ({1'b0, idx} == (n_lat - ONE_N));

    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          n_nx     = n_clip;
          loop_nx  = loop_mode;
          idx_nx   = '0;
          cnt_nx   = delay_mem[0];
          fc_nx    = '0;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // stop takes priority over both freeze and fire
        if (stop) begin
          state_nx = IDLE;
        end else if (en) begin
          if (cnt != '0) begin
            cnt_nx = cnt - 1'b1;
          end else begin
            new_nx  = fire_mask;
            data_nx = fire_data;
            fc_nx   = (fire_count == 16'hFFFF) ? fire_count : fire_count + 16'd1;
            if (!last_entry) begin
              idx_nx = idx_inc;
              cnt_nx = delay_mem[idx_inc];
            end else if (loop_lat) begin
              idx_nx = '0;
              cnt_nx = delay_mem[0];
            end else begin
              state_nx = DONE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Playback state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      n_lat      <= '0;
      loop_lat   <= 1'b0;
      data_out   <= '0;
      new_out    <= '0;
      fire_count <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      n_lat      <= n_nx;
      loop_lat   <= loop_nx;
      data_out   <= data_nx;
      new_out    <= new_nx;
      fire_count <= fc_nx;
    end
  end

endmodule

// File: tb/tb_event_trace_player.sv
// Directed bench for event_trace_player: per-cycle vector tables for the
// short sequences, hand-written sequences for long delays, stall and reset.
module tb_event_trace_player;

  logic         clk = 1'b0;
  logic         rst, en, wr_en, start, loop_mode, stop;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_delay;
  logic [1:0]   wr_mask;
  logic [127:0] wr_data;
  logic [4:0]   num_entries;
  logic [127:0] data_out;
  logic [1:0]   new_out;
  logic         busy, done;
  logic [3:0]   entry_idx;
  logic [15:0]  fire_count;

  int total = 0;
  int bad   = 0;
  int stray;

  always #5 clk = ~clk;

  event_trace_player #(
    .NUM_CH(2), .DATA_W(64), .DEPTH(16), .DELAY_W(32)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_delay(wr_delay), .wr_mask(wr_mask), .wr_data(wr_data),
    .num_entries(num_entries), .start(start), .loop_mode(loop_mode),
    .stop(stop), .data_out(data_out), .new_out(new_out), .busy(busy),
    .done(done), .entry_idx(entry_idx), .fire_count(fire_count)
  );

  typedef struct {
    logic        start;
    logic        stop;
    logic [4:0]  nent;
    logic        loop;
    logic [1:0]  e_new;
    logic [63:0] e_d0;
    logic [63:0] e_d1;
    logic        e_busy;
    logic        e_done;
    logic [3:0]  e_idx;
    logic [15:0] e_fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic st, input logic sp, input logic [4:0] ne,
                               input logic lp, input logic [1:0] nw,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic bz, input logic dn,
                               input logic [3:0] ix, input logic [15:0] fc);
    vec_t v;
    v.start = st; v.stop = sp; v.nent = ne; v.loop = lp; v.e_new = nw;
    v.e_d0 = a; v.e_d1 = b; v.e_busy = bz; v.e_done = dn; v.e_idx = ix; v.e_fc = fc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [1:0] m,
                    input logic [63:0] d0, input logic [63:0] d1);
    wr_en = 1'b1; wr_addr = a; wr_delay = d; wr_mask = m; wr_data = {d1, d0};
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] ne, input logic lp);
    start = 1'b1; num_entries = ne; loop_mode = lp;
    step();
    start = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi, input string tag);
    for (int i = lo; i <= hi; i++) begin
      start = vecs[i].start; stop = vecs[i].stop;
      num_entries = vecs[i].nent; loop_mode = vecs[i].loop;
      step();
      chk($sformatf("%s%0d.new",  tag, i), 64'(new_out),         64'(vecs[i].e_new));
      chk($sformatf("%s%0d.d0",   tag, i), data_out[63:0],       vecs[i].e_d0);
      chk($sformatf("%s%0d.d1",   tag, i), data_out[127:64],     vecs[i].e_d1);
      chk($sformatf("%s%0d.busy", tag, i), 64'(busy),            64'(vecs[i].e_busy));
      chk($sformatf("%s%0d.done", tag, i), 64'(done),            64'(vecs[i].e_done));
      chk($sformatf("%s%0d.idx",  tag, i), 64'(entry_idx),       64'(vecs[i].e_idx));
      chk($sformatf("%s%0d.fc",   tag, i), 64'(fire_count),      64'(vecs[i].e_fc));
    end
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; start = 1'b0; loop_mode = 1'b0; stop = 1'b0;
    wr_addr = '0; wr_delay = '0; wr_mask = '0; wr_data = '0; num_entries = '0;

    // Back-to-back table (indices 0..4): three delay-0 entries 5,6,7 on ch0.
    vecs.push_back(mkv(1, 0, 3, 0, 2'b00, 64'h2, 64'h0, 1, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 3, 0, 2'b01, 64'h5, 64'h0, 1, 0, 1, 1));
    vecs.push_back(mkv(0, 0, 3, 0, 2'b01, 64'h6, 64'h0, 1, 0, 2, 2));
    vecs.push_back(mkv(0, 0, 3, 0, 2'b01, 64'h7, 64'h0, 0, 1, 2, 3));
    vecs.push_back(mkv(0, 0, 3, 0, 2'b00, 64'h7, 64'h0, 0, 1, 2, 3));
    // Loop table (indices 5..22): two entries, delay 3, stop before 4th fire.
    vecs.push_back(mkv(1, 0, 2, 1, 2'b00, 64'h7, 64'h0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(0, 0, 2, 1, 2'b00, 64'h7, 64'h0, 1, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 2, 1, 2'b11, 64'hA, 64'hB, 1, 0, 1, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(0, 0, 2, 1, 2'b00, 64'hA, 64'hB, 1, 0, 1, 1));
    vecs.push_back(mkv(0, 0, 2, 1, 2'b11, 64'hC, 64'hD, 1, 0, 0, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv(0, 0, 2, 1, 2'b00, 64'hC, 64'hD, 1, 0, 0, 2));
    vecs.push_back(mkv(0, 0, 2, 1, 2'b11, 64'hA, 64'hB, 1, 0, 1, 3));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mkv(0, 0, 2, 1, 2'b00, 64'hA, 64'hB, 1, 0, 1, 3));
    vecs.push_back(mkv(0, 1, 2, 1, 2'b00, 64'hA, 64'hB, 0, 0, 1, 3));
    for (int i = 0; i < 2; i++)
      vecs.push_back(mkv(0, 0, 2, 1, 2'b00, 64'hA, 64'hB, 0, 0, 1, 3));

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst.new", 64'(new_out), 0);
    chk("rst.data", data_out[63:0] | data_out[127:64], 0);
    chk("rst.busy", 64'(busy), 0);
    chk("rst.done", 64'(done), 0);
    chk("rst.idx", 64'(entry_idx), 0);
    chk("rst.fc", 64'(fire_count), 0);

    // Start with num_entries=0 is ignored
    do_start(0, 0);
    chk("n0.busy", 64'(busy), 0);
    chk("n0.done", 64'(done), 0);

    // Basic two-channel replay with delay 999
    wr(0, 999, 2'b11, 64'h1, 64'h1);
    wr(1, 999, 2'b01, 64'h2, 64'h77);
    do_start(2, 0);
    stray = 0;
    repeat (999) begin step(); if (new_out != 0 || !busy) stray++; end
    chk("basic.quiet0", 64'(stray), 0);
    step();
    chk("basic.new0", 64'(new_out), 3);
    chk("basic.d0_0", data_out[63:0], 1);
    chk("basic.d1_0", data_out[127:64], 1);
    chk("basic.idx0", 64'(entry_idx), 1);
    stray = 0;
    repeat (999) begin step(); if (new_out != 0) stray++; end
    chk("basic.quiet1", 64'(stray), 0);
    step();
    chk("basic.new1", 64'(new_out), 1);
    chk("basic.d0_1", data_out[63:0], 2);
    chk("basic.d1_1", data_out[127:64], 0);
    chk("basic.done", 64'(done), 1);
    chk("basic.fc", 64'(fire_count), 2);
    step();
    chk("basic.newoff", 64'(new_out), 0);

    // Back-to-back, restarted from DONE
    wr(0, 0, 2'b01, 64'h5, 64'h0);
    wr(1, 0, 2'b01, 64'h6, 64'h0);
    wr(2, 0, 2'b01, 64'h7, 64'h0);
    run_vecs(0, 4, "b2b");

    // Loop mode with stop one cycle before a scheduled fire
    wr(0, 3, 2'b11, 64'hA, 64'hB);
    wr(1, 3, 2'b11, 64'hC, 64'hD);
    run_vecs(5, 22, "loop");

    // Enable stall with counter already at zero
    wr(0, 5, 2'b10, 64'h11, 64'h22);
    do_start(1, 0);
    repeat (5) step();
    chk("stall.pre", 64'(new_out), 0);
    en = 1'b0;
    stray = 0;
    repeat (10) begin step(); if (new_out != 0 || !busy) stray++; end
    chk("stall.frozen", 64'(stray), 0);
    en = 1'b1;
    step();
    chk("stall.new", 64'(new_out), 2);
    chk("stall.d0", data_out[63:0], 0);
    chk("stall.d1", data_out[127:64], 64'h22);
    chk("stall.done", 64'(done), 1);

    // Write during WAIT is dropped
    wr(0, 2, 2'b01, 64'h100, 64'h5);
    do_start(1, 0);
    wr(0, 0, 2'b11, 64'hDEAD, 64'hBEEF);
    step();
    chk("wp.quiet", 64'(new_out), 0);
    step();
    chk("wp.new", 64'(new_out), 1);
    chk("wp.d0", data_out[63:0], 64'h100);
    chk("wp.d1", data_out[127:64], 0);
    do_start(1, 0);
    step(); step();
    chk("wp2.quiet", 64'(new_out), 0);
    step();
    chk("wp2.new", 64'(new_out), 1);
    chk("wp2.d0", data_out[63:0], 64'h100);

    // num_entries beyond DEPTH plays DEPTH entries
    for (int i = 0; i < 16; i++) wr(4'(i), 0, 2'b01, 64'(i + 1), 64'h0);
    do_start(21, 0);
    repeat (15) step();
    chk("clip.busy15", 64'(busy), 1);
    chk("clip.fc15", 64'(fire_count), 15);
    step();
    chk("clip.done", 64'(done), 1);
    chk("clip.fc16", 64'(fire_count), 16);
    chk("clip.d0", data_out[63:0], 16);
    step();
    chk("clip.after", 64'(fire_count), 16);

    // Reset one cycle before a scheduled fire
    wr(0, 4, 2'b11, 64'h33, 64'h44);
    do_start(1, 0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid.new", 64'(new_out), 0);
    chk("rmid.data", data_out[63:0] | data_out[127:64], 0);
    chk("rmid.busy", 64'(busy), 0);
    chk("rmid.done", 64'(done), 0);
    chk("rmid.idx", 64'(entry_idx), 0);
    chk("rmid.fc", 64'(fire_count), 0);
    stray = 0;
    repeat (3) begin step(); if (new_out != 0) stray++; end
    chk("rmid.nopulse", 64'(stray), 0);
    do_start(1, 0);
    stray = 0;
    repeat (4) begin step(); if (new_out != 0) stray++; end
    chk("rre.quiet", 64'(stray), 0);
    step();
    chk("rre.new", 64'(new_out), 3);
    chk("rre.d0", data_out[63:0], 64'h33);
    chk("rre.d1", data_out[127:64], 64'h44);
    chk("rre.fc", 64'(fire_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_trace_player.md
Name: event_trace_player

Overview:
- Synthesizable, parametrised replacement for hand-written timed stimulus blocks that drive monitor inputs.
- Holds a programmable table of timed events. Each event is a delay, a per-channel valid mask and per-channel values.
- On start, replays the table and drives `NUM_CH` value/new-flag pairs straight into the monitor `topEntity` input ports.
- Adds what fixed stimulus lacks: runtime loading, arbitrary channel count, loop mode, stop, and pulse counting.

Parameters:
- NUM_CH, 2: number of input channels driven.
- DATA_W, 64: width of each channel value, treated as signed.
- DEPTH, 16: number of event table entries; must be at least 2.
- DELAY_W, 32: width of the per-entry delay field, in cycles.
- AW, $clog2(DEPTH): table address width (derived).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset, sampled on rising clk.
- en  in  1  global enable; when low, the block freezes.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table entry index.
- wr_delay  in  DELAY_W  cycles to wait before this entry fires.
- wr_mask  in  NUM_CH  channels that receive a new value.
- wr_data  in  NUM_CH*DATA_W  channel values; channel k is bits [k*DATA_W +: DATA_W].
- num_entries  in  AW+1  number of entries to play; sampled at start.
- start  in  1  begin playback; level-sampled.
- loop_mode  in  1  1 = wrap to entry 0 after the last entry; sampled at start.
- stop  in  1  abort playback.
- data_out  out  NUM_CH*DATA_W  registered channel values.
- new_out  out  NUM_CH  registered one-cycle new-value flags.
- busy  out  1  high while in WAIT.
- done  out  1  high while in DONE.
- entry_idx  out  AW  index of the entry currently pending.
- fire_count  out  16  number of fire events since the last start; saturates at 0xFFFF.

Behaviour:
- States: IDLE, WAIT, DONE. All outputs are registered.
- Reset: state goes to IDLE. data_out, new_out, busy, done, entry_idx and fire_count all go to 0. Table contents are not cleared.
- Table write: takes effect when wr_en is high at an edge and state is not WAIT. A write while busy is silently dropped. A table read sees a same-cycle write only from the next cycle on.
- Start is accepted at edge E when all of the following hold: state is IDLE or DONE, en=1, start=1, num_entries≠0.
- On an accepted start:
  - latch N = min(num_entries, DEPTH) and loop_mode;
  - set idx=0 and load counter=delay[0];
  - clear fire_count; state goes to WAIT.
- Start with num_entries=0 is ignored.
- Fire: on a WAIT edge with en=1 and counter==0, the current entry fires.
  - new_out takes mask[idx] for exactly one cycle.
  - data_out takes data[idx], with unmasked channel lanes forced to 0.
  - fire_count increments, saturating at 0xFFFF.
- After a fire:
  - if idx<N-1: idx increments and counter loads delay[idx+1];
  - else if loop mode is latched: idx goes to 0 and counter loads delay[0];
  - else: state goes to DONE and done=1.
- Timing: entry 0 is visible in the cycle after edge E+D0+1. A later entry i is visible Di+1 cycles after the previous pulse. Delay 0 therefore gives back-to-back pulses.
- WAIT with en=1 and counter≠0: counter decrements. new_out=0 and data_out is held.
- An entry with mask=0 still counts as a fire and advances the table. new_out stays 0 and data_out goes to all zeros.
- en=0: the counter and state freeze, new_out is forced to 0, and data_out is held.
- stop=1 at a WAIT edge: state goes to IDLE and busy=0, and no fire occurs that edge (stop beats fire). stop=1 in IDLE or DONE has no effect.
- start while in WAIT is ignored. start in DONE restarts playback and clears done.
- rst mid-playback aborts on that edge; no pulse is issued.
- busy = (state==WAIT); done = (state==DONE).
- Delay arithmetic is unsigned DELAY_W with no overflow. Data passes through unmodified.

Test Plan:
- Basic two-channel replay. Load 2 entries: (delay 999, mask 11, data 1/1) and (delay 999, mask 01, data 2/0). Start at edge E.
  - new_out=11 with data 1/1 in the cycle after E+1000.
  - new_out=01 with data 2/0 exactly 1000 cycles later.
  - done=1 and fire_count=2 afterwards.
- Back-to-back. Load 3 entries with delay 0 and data 5, 6, 7 on channel 0.
  - Three consecutive one-cycle pulses on channel 0 carrying 5, 6, 7, then done.
- Loop mode. N=2, delays 3 and 3, loop_mode=1.
  - Pulses every 4 cycles, entry_idx alternates 0,1,0,…
  - stop asserted one cycle before a scheduled fire: no pulse, back to IDLE, fire_count holds.
- Enable stall. Delay 5, en low for 10 cycles during WAIT.
  - Pulse is delayed by exactly 10 cycles; new_out=0 while en=0.
- Write protection and edge cases.
  - wr_en during WAIT leaves table contents unchanged.
  - num_entries=0 with start leaves state IDLE.
  - num_entries=DEPTH+5 plays DEPTH entries.
- Reset mid-WAIT. Assert rst one cycle before a scheduled fire.
  - All outputs are 0 on the next cycle and no pulse appears.
  - Restart without reloading replays the unchanged table.
